// File: rtl/p_sched_pkg.sv
// rtl/p_sched_pkg.sv - shared constants for the PRESENT-80 request scheduler
package p_sched_pkg;

  localparam int BLK_W  = 64;
  localparam int KEY_W  = 80;
  localparam int ROUNDS = 31;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/p_rr_arb.sv
// rtl/p_rr_arb.sv - combinational round-robin arbiter
// Ports: req   - request vector, one bit per requester
//        ptr   - index with highest priority this cycle
//        grant - one-hot grant, zero when nothing requests
//        idx   - binary index of the granted requester
//        any   - at least one requester is granted
module p_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int              sum;
  logic [ID_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest requester at or
  // after ptr is the last one written and therefore wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = ID_W'(sum);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/p_sched.sv
// rtl/p_sched.sv - round-robin scheduler sharing one PRESENT-80 core
// Ports: sys_clk, sys_rst_n            - clock, synchronous active-low reset
//        req_valid/req_ready           - per-requester handshake
//        req_data/req_key              - per-requester plaintext and key slices
//        rsp_valid/rsp_ready           - shared response handshake
//        rsp_id/rsp_data/rsp_err       - response tag, ciphertext, timeout flag
//        core_state/core_keys          - operands presented to the core
//        core_start                    - low loads operands, high runs the core
//        core_done/core_result         - core finish pulse and ciphertext
module p_sched
  import p_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 40
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*BLK_W-1:0] req_data,
  input  logic [N_REQ*KEY_W-1:0] req_key,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [BLK_W-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic [BLK_W-1:0]       core_state,
  output logic [KEY_W-1:0]       core_keys,
  output logic                   core_start,
  input  logic                   core_done,
  input  logic [BLK_W-1:0]       core_result
);

  localparam int WD_W = $clog2(TIMEOUT);

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  cur_id;
  logic [WD_W-1:0]  watchdog;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gidx;
  logic             gany;

  p_rr_arb #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(grant),
    .idx  (gidx),
    .any  (gany)
  );

  // Ready is withheld while reset is asserted so no handshake can appear to
  // complete on a cycle the FSM is being cleared.
  assign req_ready  = (state == ST_IDLE && sys_rst_n) ? grant : '0;
  assign rsp_valid  = (state == ST_RESP);
  assign core_start = (state == ST_RUN);
  assign rsp_id     = cur_id;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cur_id     <= '0;
      watchdog   <= '0;
      core_state <= '0;
      core_keys  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gany) begin
            core_state <= req_data[gidx*BLK_W +: BLK_W];
            core_keys  <= req_key[gidx*KEY_W +: KEY_W];
            cur_id     <= gidx;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          watchdog <= '0;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          // A done arriving on the final watchdog cycle still counts as success.
          if (core_done) begin
            rsp_data <= core_result;
            rsp_err  <= 1'b0;
            state    <= ST_RESP;
          end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= ST_RESP;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            ptr   <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p_sched.sv
// tb/tb_p_sched.sv - self-checking bench for p_sched with a PRESENT-80 core stub
module tb_p_sched;
  import p_sched_pkg::*;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 40;

  logic                   sys_clk = 1'b0;
  logic                   sys_rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*64-1:0]    req_data;
  logic [N_REQ*80-1:0]    req_key;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [63:0]            rsp_data;
  logic                   rsp_err;
  logic [63:0]            core_state;
  logic [79:0]            core_keys;
  logic                   core_start;
  logic                   core_done;
  logic [63:0]            core_result;

  p_sched #(
    .N_REQ  (N_REQ),
    .ID_W   (ID_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_key    (req_key),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .core_state (core_state),
    .core_keys  (core_keys),
    .core_start (core_start),
    .core_done  (core_done),
    .core_result(core_result)
  );

  always #5 sys_clk = ~sys_clk;

  int cycle = 0;
  always @(posedge sys_clk) cycle <= cycle + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
      4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
      4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
      4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= ROUNDS; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb(s[n*4 +: 4]);
      t = '0;
      for (int b = 0; b < 63; b++) t[(b*16) % 63] = s[b];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Core stub: samples operands while core_start is low, raises done in the
  // done_at-th run cycle (0 = never), plus an injectable stray done.
  int          done_at = 32;
  logic        stray_done = 1'b0;
  int          stub_cnt;
  logic [63:0] stub_res;

  always @(posedge sys_clk) begin
    if (!core_start) begin
      stub_cnt <= 0;
      stub_res <= present80(core_state, core_keys);
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign core_done   = (core_start && done_at != 0 && stub_cnt == done_at - 1) || stray_done;
  assign core_result = core_done ? stub_res : 64'hDEAD_BEEF_0BAD_F00D;

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_req_ready"}, req_ready, 0);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_err"}, rsp_err, 0);
    check({pfx, "_rsp_id"}, rsp_id, 0);
    check({pfx, "_rsp_data"}, rsp_data, 0);
    check({pfx, "_core_start"}, core_start, 0);
    check({pfx, "_core_state"}, core_state, 0);
    check({pfx, "_core_keys"}, core_keys, 0);
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < N_REQ * 2; i++) req_data[i*32 +: 32] = $urandom;
    for (int i = 0; i < N_REQ * 80 / 16; i++) req_key[i*16 +: 16] = 16'($urandom);
  endtask

  // One transaction from grant to response handshake, entered and left just
  // after a falling edge with the scheduler idle.
  task automatic run_one(input logic [3:0] mask, input int hold,
                         output logic [1:0] got_id, output logic [63:0] got_data);
    int          g;
    int          c0;
    int          exp_lat;
    bit          err_exp;
    bit          seen;
    bit          bad_ready;
    bit          bad_run;
    bit          bad_hold;
    logic [63:0] pt;
    logic [79:0] key;
    logic [63:0] exp_data;
    g = -1;
    for (int i = 0; i < N_REQ; i++) begin
      int c;
      c = (m_ptr + i) % N_REQ;
      if (g < 0 && mask[c]) g = c;
    end
    err_exp  = (done_at == 0 || done_at > TIMEOUT);
    exp_lat  = err_exp ? TIMEOUT + 2 : done_at + 2;
    pt       = req_data[g*64 +: 64];
    key      = req_key[g*80 +: 80];
    exp_data = err_exp ? 64'd0 : present80(pt, key);
    got_id   = '0;
    got_data = '0;

    req_valid = mask;
    #1;
    check("grant", req_ready, 80'(4'b0001 << g));
    c0 = cycle;
    @(negedge sys_clk);
    check("load_start", core_start, 0);
    check("load_state", core_state, pt);
    check("load_keys", core_keys, key);

    seen      = 1'b0;
    bad_ready = 1'b0;
    bad_run   = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge sys_clk);
      if (rsp_valid) seen = 1'b1;
      else begin
        if (req_ready != 0) bad_ready = 1'b1;
        if (!core_start || core_state !== pt || core_keys !== key) bad_run = 1'b1;
      end
    end
    check("rsp_seen", seen, 1);
    if (!seen) return;
    check("run_ready_low", bad_ready, 0);
    check("run_stable", bad_run, 0);
    check("latency", cycle - c0, exp_lat);
    check("rsp_id", rsp_id, g);
    check("rsp_err", rsp_err, err_exp);
    check("rsp_data", rsp_data, exp_data);
    check("resp_start", core_start, 0);
    got_id   = rsp_id;
    got_data = rsp_data;

    bad_hold = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge sys_clk);
      if (!rsp_valid || rsp_id !== got_id || rsp_data !== got_data ||
          rsp_err !== err_exp || req_ready != 0) bad_hold = 1'b1;
    end
    if (hold > 0) check("hold_stable", bad_hold, 0);

    rsp_ready = 1'b1;
    @(posedge sys_clk);
    #1 rsp_ready = 1'b0;
    @(negedge sys_clk);
    check("rsp_drop", rsp_valid, 0);
    m_ptr = (g + 1) % N_REQ;
  endtask

  int          order[5] = '{0, 1, 2, 3, 0};
  logic [1:0]  id;
  logic [63:0] dat;
  bit          bad;

  initial begin
    sys_rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_data  = '0;
    req_key   = '0;
    repeat (3) @(negedge sys_clk);
    check_reset_outs("reset");
    sys_rst_n = 1'b1;
    m_ptr = 0;
    @(negedge sys_clk);

    // Known-answer vectors
    randomize_operands();
    req_data[0*64 +: 64] = 64'd0;
    req_key[0*80 +: 80]  = 80'd0;
    run_one(4'b0001, 0, id, dat);
    check("kat0_data", dat, 64'h5579C1387B228445);
    check("kat0_id", id, 0);

    randomize_operands();
    req_data[1*64 +: 64] = 64'd0;
    req_key[1*80 +: 80]  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    run_one(4'b0010, 0, id, dat);
    check("kat1_data", dat, 64'hE72C46C0F5945049);
    check("kat1_id", id, 1);

    // Watchdog timeout, then a normal run from the same requester
    randomize_operands();
    done_at = 0;
    run_one(4'b0100, 0, id, dat);
    done_at = 32;
    run_one(4'b0100, 0, id, dat);

    // Done on the last watchdog cycle must not be reported as an error
    done_at = TIMEOUT;
    run_one(4'b1000, 0, id, dat);
    done_at = 32;

    // Response backpressure for 10 cycles
    randomize_operands();
    run_one(4'b0011, 10, id, dat);

    // Reset in the middle of a run
    randomize_operands();
    req_valid = 4'b0100;
    repeat (12) @(negedge sys_clk);
    check("mid_run_start", core_start, 1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_reset_outs("mid_rst");
    sys_rst_n = 1'b1;
    req_valid = '0;
    m_ptr = 0;
    bad = 1'b0;
    repeat (50) begin
      @(negedge sys_clk);
      if (rsp_valid) bad = 1'b1;
    end
    check("no_rsp_after_rst", bad, 0);

    // Stray done while idle
    stray_done = 1'b1;
    bad = 1'b0;
    repeat (2) begin
      @(negedge sys_clk);
      if (rsp_valid || core_start) bad = 1'b1;
    end
    stray_done = 1'b0;
    check("stray_done_ignored", bad, 0);

    // All requesters held valid: fair rotation from pointer 0
    for (int k = 0; k < 5; k++) begin
      randomize_operands();
      run_one(4'b1111, 0, id, dat);
      check("rr_order", id, order[k]);
    end
    req_valid = '0;

    // Randomized traffic
    for (int t = 0; t < 12; t++) begin
      int r;
      randomize_operands();
      r = $urandom_range(0, 5);
      done_at = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, TIMEOUT) : 32;
      run_one(4'($urandom_range(1, 15)), $urandom_range(0, 3), id, dat);
    end
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
